pedal_chain: RTL and testbench
==============================

PEDAL_CHAIN -- requirements
Module: pedal_chain

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning signed sample width.
REQ-002 SHALL provide parameter NUM_STAGES, default 4, meaning number of pedal slots in series.
REQ-003 SHALL provide parameter RAMP_LOG2, default 6, meaning crossfade length of 2^RAMP_LOG2 samples (M = 2^RAMP_LOG2).
REQ-004 SHALL provide parameter DEBOUNCE, default 1024, meaning clocks a synchronised switch must be stable before it is accepted.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: Clk in 1 (system clock); Reset in 1 (async, active-high).
REQ-006 Signal_in in WIDTH: signed input sample.
REQ-007 In_valid in 1: Signal_in valid this cycle.
REQ-008 Switches in NUM_STAGES: bit k enables slot k; asynchronous to Clk.
REQ-009 Wet_send out NUM_STAGES*WIDTH: slice k = dry sample entering slot k.
REQ-010 Wet_return in NUM_STAGES*WIDTH: slice k = external effect output, combinational from Wet_send slice k in the same cycle.
REQ-011 Signal_out out WIDTH: signed output sample.
REQ-012 Out_valid out 1: Signal_out valid this cycle, one-cycle pulse per sample.
REQ-013 Stage_active out NUM_STAGES: bit k high when slot k gain equals M.

Function
REQ-014 Slot 0 input SHALL be Signal_in/In_valid; slot k>0 input SHALL be slot k-1 registered sample/valid; Signal_out/Out_valid SHALL be the last slot's registers.
REQ-015 Each slot SHALL register its mixed sample and valid bit when its input valid is high; the valid register SHALL be 0 on other cycles; latency In_valid to Out_valid = NUM_STAGES clocks exactly.
REQ-016 Wet_send slice k SHALL equal slot k's input sample.
REQ-017 Mix SHALL be (dry*(M-g) + wet*g) >>> RAMP_LOG2, signed, computed in WIDTH+RAMP_LOG2+2 bits, floor rounding; result SHALL never overflow WIDTH.
REQ-018 g=0 SHALL give output = dry exactly; g=M SHALL give output = wet exactly.
REQ-019 Each switch bit SHALL pass a 2-flop synchroniser, then a debounce counter: target changes only after DEBOUNCE consecutive equal synchronised samples differing from the current target; any toggle restarts the count.
REQ-020 Per-slot FSM states: BYPASSED (g=0), FADE_IN, ACTIVE (g=M), FADE_OUT.
REQ-021 BYPASSED->FADE_IN when target=1; ACTIVE->FADE_OUT when target=0.
REQ-022 FADE_IN: g+1 per accepted input sample; reaching M -> ACTIVE. FADE_OUT: g-1 per accepted sample; reaching 0 -> BYPASSED.
REQ-023 Target change mid-fade SHALL reverse direction from current g (FADE_IN<->FADE_OUT) with no jump.
REQ-024 g SHALL hold when slot input valid is low; mix in a cycle SHALL use g before that cycle's update.
REQ-025 Stage_active[k] SHALL be registered, high only in ACTIVE.

Reset
REQ-026 Reset SHALL asynchronously clear all sample registers, valid registers, Signal_out, Out_valid, Stage_active, synchronisers, debounce counters and targets to 0, g to 0, FSMs to BYPASSED.
REQ-027 Reset mid-fade or mid-pipeline SHALL discard in-flight samples; no Out_valid pulse until a new In_valid after release.

Structure
REQ-028 Package pedal_pkg SHALL hold the slot state enum and default parameter constants.
REQ-029 Sub-module pedal_slot SHALL implement one slot (synchroniser, debounce, FSM, gain counter, mixer, registers); pedal_chain SHALL instantiate NUM_STAGES of them via generate.

Verification (WIDTH=16, NUM_STAGES=4, RAMP_LOG2=2, DEBOUNCE=4)
REQ-030 Reset, Switches=0, In_valid with 0x1234 -> Out_valid exactly 4 clocks later, Signal_out=0x1234, Stage_active=0.
REQ-031 Wet_return[0]=-Wet_send[0], Switches[0]=1 held past sync+debounce, constant input 1000 -> successive outputs 1000,500,0,-500,-1000 then steady -1000; Stage_active[0] rises after g=4.
REQ-032 Switches[0] pulsed high for 3 clocks -> no FSM change, output stays = dry.
REQ-033 Switch off while slot 0 FADE_IN at g=2 -> g sequence 2,1,0, outputs 0,500,1000, state BYPASSED.
REQ-034 dry=-32768, wet=32767, g=2 -> Signal_out=-1, no wrap.
REQ-035 Reset asserted mid-fade with samples in flight -> Out_valid, Stage_active, Signal_out 0 immediately; first output after release equals dry input.

Source files
------------

// File: rtl/pedal_pkg.sv
// Shared types and default constants for the pedal chain.
package pedal_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_NUM_STAGES = 4;
   localparam int DEF_RAMP_LOG2  = 6;
   localparam int DEF_DEBOUNCE   = 1024;

   // Per-slot crossfade state. The gain is 0 in BYPASSED and M in ACTIVE.
   typedef enum logic [1:0] {
      ST_BYPASSED = 2'd0,
      ST_FADE_IN  = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_FADE_OUT = 2'd3
   } slot_state_t;

endpackage

// File: rtl/pedal_slot.sv
// One pedal slot: switch synchroniser and debounce, crossfade FSM with gain
// counter, dry/wet mixer and the registered sample/valid stage.
module pedal_slot
   import pedal_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int RAMP_LOG2 = DEF_RAMP_LOG2,
   parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_sample,
   input  logic             i_valid,
   input  logic             i_switch,
   input  logic [WIDTH-1:0] i_wet,
   output logic [WIDTH-1:0] o_sample,
   output logic             o_valid,
   output logic             o_active,
   output slot_state_t      o_state
);

   localparam int GW = RAMP_LOG2 + 1;            // gain range 0..M
   localparam int MW = WIDTH + RAMP_LOG2 + 2;    // mixer width
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [GW-1:0] GAIN_MAX = GW'(1 << RAMP_LOG2);
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

   logic [1:0]          r_sync;
   logic [CW-1:0]       r_db_cnt;
   logic                r_target;
   slot_state_t         r_state;
   logic [GW-1:0]       r_gain;
   logic                r_active;
   logic [WIDTH-1:0]    r_sample;
   logic                r_valid;

   logic signed [MW-1:0] w_dry_x;
   logic signed [MW-1:0] w_wet_x;
   logic signed [MW-1:0] w_g_x;
   logic signed [MW-1:0] w_ig_x;
   logic signed [MW-1:0] w_sum;
   logic signed [MW-1:0] w_shift;

   // Two-flop synchroniser for the asynchronous footswitch.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_sync <= '0;
      else         r_sync <= {r_sync[0], i_switch};
   end

   // Debounce: the target follows only after DEBOUNCE consecutive differing samples.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_db_cnt <= '0;
         r_target <= 1'b0;
      end else if (r_sync[1] == r_target) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
         r_target <= r_sync[1];
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + CW'(1);
      end
   end

   // Crossfade FSM; the gain steps once per accepted sample and reverses in place.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= ST_BYPASSED;
         r_gain   <= '0;
         r_active <= 1'b0;
      end else begin
         case (r_state)
            ST_BYPASSED: begin
               if (r_target) r_state <= ST_FADE_IN;
            end
            ST_FADE_IN: begin
               if (!r_target) begin
                  r_state <= ST_FADE_OUT;
               end else if (r_gain == GAIN_MAX) begin
                  r_state  <= ST_ACTIVE;
                  r_active <= 1'b1;
               end else if (i_valid) begin
                  r_gain <= r_gain + GW'(1);
                  if (r_gain == GAIN_MAX - GW'(1)) begin
                     r_state  <= ST_ACTIVE;
                     r_active <= 1'b1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (!r_target) begin
                  r_state  <= ST_FADE_OUT;
                  r_active <= 1'b0;
               end
            end
            ST_FADE_OUT: begin
               if (r_target) begin
                  r_state <= ST_FADE_IN;
               end else if (r_gain == '0) begin
                  r_state <= ST_BYPASSED;
               end else if (i_valid) begin
                  r_gain <= r_gain - GW'(1);
                  if (r_gain == GW'(1)) r_state <= ST_BYPASSED;
               end
            end
            default: begin
               r_state  <= ST_BYPASSED;
               r_gain   <= '0;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   // Mixer: (dry*(M-g) + wet*g) >>> RAMP_LOG2 using the pre-update gain.
   // The wide sum cannot overflow and the floored result always fits WIDTH.
   assign w_dry_x = {{(MW-WIDTH){i_sample[WIDTH-1]}}, i_sample};
   assign w_wet_x = {{(MW-WIDTH){i_wet[WIDTH-1]}}, i_wet};
   assign w_g_x   = {{(MW-GW){1'b0}}, r_gain};
   assign w_ig_x  = $signed(MW'(1 << RAMP_LOG2)) - w_g_x;
   assign w_sum   = (w_dry_x * w_ig_x) + (w_wet_x * w_g_x);
   assign w_shift = w_sum >>> RAMP_LOG2;

   // Output stage: capture the mix on accepted samples, valid is a one-cycle pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sample <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= i_valid;
         if (i_valid) r_sample <= w_shift[WIDTH-1:0];
      end
   end

   assign o_sample = r_sample;
   assign o_valid  = r_valid;
   assign o_active = r_active;
   assign o_state  = r_state;

endmodule

// File: rtl/pedal_chain.sv
// Series chain of pedal slots with per-slot send/return effect loops.
// Stream semantics: a sample moves only on a cycle where its valid is high;
// there is no back-pressure, so each slot accepts every valid sample and
// presents it one clock later with a single-cycle valid pulse.
module pedal_chain
   import pedal_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int RAMP_LOG2  = DEF_RAMP_LOG2,
   parameter int DEBOUNCE   = DEF_DEBOUNCE
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [WIDTH-1:0]            i_signal_in,
   input  logic                        i_in_valid,
   input  logic [NUM_STAGES-1:0]       i_switches,
   output logic [NUM_STAGES*WIDTH-1:0] o_wet_send,
   input  logic [NUM_STAGES*WIDTH-1:0] i_wet_return,
   output logic [WIDTH-1:0]            o_signal_out,
   output logic                        o_out_valid,
   output logic [NUM_STAGES-1:0]       o_stage_active,
   output logic [2*NUM_STAGES-1:0]     o_dbg_state
);

   logic [WIDTH-1:0] w_chain_sample [NUM_STAGES+1];
   logic             w_chain_valid  [NUM_STAGES+1];
   slot_state_t      w_state        [NUM_STAGES];

   assign w_chain_sample[0] = i_signal_in;
   assign w_chain_valid[0]  = i_in_valid;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
      pedal_slot #(
         .WIDTH     (WIDTH),
         .RAMP_LOG2 (RAMP_LOG2),
         .DEBOUNCE  (DEBOUNCE)
      ) u_slot (
         .i_clk    (i_clk),
         .i_reset  (i_reset),
         .i_sample (w_chain_sample[k]),
         .i_valid  (w_chain_valid[k]),
         .i_switch (i_switches[k]),
         .i_wet    (i_wet_return[k*WIDTH +: WIDTH]),
         .o_sample (w_chain_sample[k+1]),
         .o_valid  (w_chain_valid[k+1]),
         .o_active (o_stage_active[k]),
         .o_state  (w_state[k])
      );
      assign o_wet_send[k*WIDTH +: WIDTH] = w_chain_sample[k];
      assign o_dbg_state[2*k +: 2]        = w_state[k];
   end

   assign o_signal_out = w_chain_sample[NUM_STAGES];
   assign o_out_valid  = w_chain_valid[NUM_STAGES];

endmodule

// File: tb/tb_pedal_chain.sv
// Scoreboard bench for pedal_chain (WIDTH=16, NUM_STAGES=4, RAMP_LOG2=2, DEBOUNCE=4).
module tb_pedal_chain;
   import pedal_pkg::*;

   localparam int W  = 16;
   localparam int NS = 4;
   localparam int RL = 2;
   localparam int DB = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [W-1:0]    sig_in = '0;
   logic            in_valid = 1'b0;
   logic [NS-1:0]   switches = '0;
   logic [NS*W-1:0] wet_send;
   logic [NS*W-1:0] wet_return;
   logic [W-1:0]    sig_out;
   logic            out_valid;
   logic [NS-1:0]   stage_active;
   logic [2*NS-1:0] dbg_state;
   logic            wet_const = 1'b0;

   logic [W-1:0] exp_q[$];
   int           t_q[$];
   int           cycle_cnt = 0;
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] mon_exp;
   int           mon_t;

   pedal_chain #(
      .WIDTH      (W),
      .NUM_STAGES (NS),
      .RAMP_LOG2  (RL),
      .DEBOUNCE   (DB)
   ) dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_signal_in    (sig_in),
      .i_in_valid     (in_valid),
      .i_switches     (switches),
      .o_wet_send     (wet_send),
      .i_wet_return   (wet_return),
      .o_signal_out   (sig_out),
      .o_out_valid    (out_valid),
      .o_stage_active (stage_active),
      .o_dbg_state    (dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // external effects: slot 0 inverts (or returns full-scale positive), others pass through
   always_comb begin
      wet_return = wet_send;
      if (wet_const) wet_return[W-1:0] = 16'h7FFF;
      else           wet_return[W-1:0] = 16'h0000 - wet_send[W-1:0];
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_sw0(input logic v);
      @(negedge clk);
      switches[0] = v;
   endtask

   task automatic send(input logic [W-1:0] s, input logic [W-1:0] e);
      @(negedge clk);
      sig_in   = s;
      in_valid = 1'b1;
      exp_q.push_back(e);
      t_q.push_back(cycle_cnt);
      #1;
      check_val("wet_send0", {16'h0, wet_send[W-1:0]}, {16'h0, s});
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // scoreboard monitor: compare value and 4-clock latency of every output
   always begin
      @(posedge clk);
      #1;
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_out", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_t   = t_q.pop_front();
            check_val("sample", {16'h0, sig_out}, {16'h0, mon_exp});
            check_val("latency", cycle_cnt - mon_t, 32'd4);
         end
      end
   end

   initial begin
      // reset state
      idle(2);
      check_val("rst_out_valid", {31'h0, out_valid}, 32'd0);
      check_val("rst_sig_out", {16'h0, sig_out}, 32'd0);
      check_val("rst_active", {28'h0, stage_active}, 32'd0);
      check_val("rst_state", {24'h0, dbg_state}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // all bypassed: output equals input after 4 clocks
      send(16'h1234, 16'h1234);
      idle(6);
      check_val("bypass_active", {28'h0, stage_active}, 32'd0);

      // 3-clock switch glitch is rejected by the debounce
      set_sw0(1'b1);
      idle(2);
      set_sw0(1'b0);
      idle(12);
      check_val("glitch_state", {30'h0, dbg_state[1:0]}, {30'h0, ST_BYPASSED});
      send(16'd777, 16'd777);
      idle(6);

      // fade in with inverted wet: 1000,500,0,-500,-1000 then steady
      set_sw0(1'b1);
      idle(12);
      check_val("fadein_state", {30'h0, dbg_state[1:0]}, {30'h0, ST_FADE_IN});
      send(16'd1000, 16'd1000);
      send(16'd1000, 16'd500);
      send(16'd1000, 16'd0);
      check_val("active_early", {31'h0, stage_active[0]}, 32'd0);
      send(16'd1000, 16'(-500));
      check_val("active_rise", {31'h0, stage_active[0]}, 32'd1);
      check_val("active_state", {30'h0, dbg_state[1:0]}, {30'h0, ST_ACTIVE});
      send(16'd1000, 16'(-1000));
      send(16'd1000, 16'(-1000));
      send(16'd1000, 16'(-1000));
      idle(6);

      // reset mid fade-out with samples in flight
      set_sw0(1'b0);
      idle(12);
      check_val("fadeout_state", {30'h0, dbg_state[1:0]}, {30'h0, ST_FADE_OUT});
      check_val("fadeout_active", {31'h0, stage_active[0]}, 32'd0);
      send(16'd1000, 16'(-1000));
      send(16'd1000, 16'(-500));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("midrst_out_valid", {31'h0, out_valid}, 32'd0);
      check_val("midrst_sig_out", {16'h0, sig_out}, 32'd0);
      check_val("midrst_active", {28'h0, stage_active}, 32'd0);
      check_val("midrst_state", {30'h0, dbg_state[1:0]}, {30'h0, ST_BYPASSED});
      exp_q.delete();
      t_q.delete();
      idle(2);
      rst = 1'b0;
      idle(6);
      check_val("post_rst_quiet", {31'h0, out_valid}, 32'd0);
      send(16'd321, 16'd321);
      idle(6);

      // reverse mid fade-in at g=2: outputs 0,500,1000 and back to bypassed
      set_sw0(1'b1);
      idle(12);
      send(16'd1000, 16'd1000);
      send(16'd1000, 16'd500);
      set_sw0(1'b0);
      idle(12);
      check_val("reverse_state", {30'h0, dbg_state[1:0]}, {30'h0, ST_FADE_OUT});
      send(16'd1000, 16'd0);
      send(16'd1000, 16'd500);
      check_val("reverse_done", {30'h0, dbg_state[1:0]}, {30'h0, ST_BYPASSED});
      send(16'd1000, 16'd1000);
      idle(6);

      // extreme mix at g=2: dry=-32768, wet=32767 -> -1
      set_sw0(1'b1);
      idle(12);
      send(16'd1000, 16'd1000);
      send(16'd1000, 16'd500);
      wet_const = 1'b1;
      send(16'h8000, 16'hFFFF);
      idle(6);
      wet_const = 1'b0;

      idle(8);
      check_val("drain", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
